instr_fetch_sequencer: RTL

//  Front-end fetch controller feeding InstrDecoder. Fetches 16-bit halfwords

---
 rtl/instr_fetch_sequencer_pkg.sv | 26 ++
 rtl/instr_fetch_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and encodings for the instruction fetch front end.
package pkg_cpu;

    // Fetch controller states; DRAIN waits out a bus read orphaned by a redirect.
    typedef enum logic [2:0] {
        FETCH_HW0 = 3'd0,
        FETCH_HW1 = 3'd1,
        FETCH_HW2 = 3'd2,
        PRESENT   = 3'd3,
        DRAIN     = 3'd4
    } fetch_state_t;

    // Location of the instruction-length group field inside hw0.
    localparam int CPU_IE_HW0_ENC_GROUP_MSB = 15;
    localparam int CPU_IE_HW0_ENC_GROUP_LSB = 14;

    // Length map: group 0 -> 1 halfword, groups 1/2 -> 2, group 3 -> 3.
    function automatic logic [1:0] instr_num_hws(input logic [1:0] group);
        case (group)
            2'd0:       return 2'd1;
            2'd1, 2'd2: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Fetch controller: reads halfwords over a req/ack port, assembles 1-3
// halfword instructions into {hw0,hw1,hw2} and hands them to decode.
//
// Handshakes:
//  - memory port: a transfer completes in any cycle with mem_req & mem_ack.
//    Once raised, mem_req and mem_addr hold until acked (no abort).
//  - decode port: handoff happens in any cycle with instr_valid & instr_ready.
//    While instr_valid & !instr_ready, all instr_* outputs hold stable.
//    A branch_valid in the handoff cycle voids the handoff.
module instr_fetch_sequencer
    import pkg_cpu::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [47:0]           instr_word,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [1:0]            instr_num_hws,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output fetch_state_t          dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] HW_STEP = ADDR_WIDTH'(2);

    fetch_state_t          state_q, state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_n;
    logic [ADDR_WIDTH-1:0] drain_pc_q, drain_pc_n;
    logic                  req_q, req_n;
    logic                  valid_q, valid_n;
    logic [15:0]           hw0_q, hw0_n;
    logic [15:0]           hw1_q, hw1_n;
    logic [15:0]           hw2_q, hw2_n;
    logic [ADDR_WIDTH-1:0] pc_q, pc_n;
    logic [1:0]            num_q, num_n;

    logic                  ack_fire;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic [1:0]            new_len;

    assign ack_fire  = req_q & mem_ack;
    assign branch_pc = {branch_target[ADDR_WIDTH-1:1], 1'b0};
    assign new_len   = pkg_cpu::instr_num_hws(
                           mem_rdata[CPU_IE_HW0_ENC_GROUP_MSB:CPU_IE_HW0_ENC_GROUP_LSB]);

    assign mem_req       = req_q;
    assign mem_addr      = fetch_pc_q;
    assign instr_valid   = valid_q;
    assign instr_word    = {hw0_q, hw1_q, hw2_q};
    assign instr_pc      = pc_q;
    assign instr_num_hws = num_q;
    assign dbg_state     = state_q;

    // State and datapath registers; reset returns everything to idle at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_HW0;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            hw0_q      <= '0;
            hw1_q      <= '0;
            hw2_q      <= '0;
            pc_q       <= '0;
            num_q      <= '0;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            drain_pc_q <= drain_pc_n;
            req_q      <= req_n;
            valid_q    <= valid_n;
            hw0_q      <= hw0_n;
            hw1_q      <= hw1_n;
            hw2_q      <= hw2_n;
            pc_q       <= pc_n;
            num_q      <= num_n;
        end
    end

    // Next-state, assembly and bus control; a redirect overrides everything.
    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        drain_pc_n = drain_pc_q;
        valid_n    = valid_q;
        hw0_n      = hw0_q;
        hw1_n      = hw1_q;
        hw2_n      = hw2_q;
        pc_n       = pc_q;
        num_n      = num_q;

        if (branch_valid) begin
            valid_n = 1'b0;
            if (req_q && !mem_ack) begin
                // Read in flight: let it finish, remember only the newest target.
                state_n    = DRAIN;
                drain_pc_n = branch_pc;
            end else begin
                // Bus idle or completing now: drop any data, restart at target.
                state_n    = FETCH_HW0;
                fetch_pc_n = branch_pc;
            end
        end else begin
            case (state_q)
                FETCH_HW0: begin
                    if (ack_fire) begin
                        hw0_n      = mem_rdata;
                        hw1_n      = '0;
                        hw2_n      = '0;
                        pc_n       = fetch_pc_q;
                        num_n      = new_len;
                        fetch_pc_n = fetch_pc_q + HW_STEP;
                        if (new_len == 2'd1) begin
                            state_n = PRESENT;
                            valid_n = 1'b1;
                        end else begin
                            state_n = FETCH_HW1;
                        end
                    end
                end
                FETCH_HW1: begin
                    if (ack_fire) begin
                        hw1_n      = mem_rdata;
                        fetch_pc_n = fetch_pc_q + HW_STEP;
                        if (num_q == 2'd2) begin
                            state_n = PRESENT;
                            valid_n = 1'b1;
                        end else begin
                            state_n = FETCH_HW2;
                        end
                    end
                end
                FETCH_HW2: begin
                    if (ack_fire) begin
                        hw2_n      = mem_rdata;
                        fetch_pc_n = fetch_pc_q + HW_STEP;
                        state_n    = PRESENT;
                        valid_n    = 1'b1;
                    end
                end
                PRESENT: begin
                    if (instr_ready) begin
                        state_n = FETCH_HW0;
                        valid_n = 1'b0;
                    end
                end
                DRAIN: begin
                    if (ack_fire) begin
                        state_n    = FETCH_HW0;
                        fetch_pc_n = drain_pc_q;
                    end
                end
                default: begin
                    state_n = FETCH_HW0;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    // Request whenever the next state still needs a halfword from memory.
    always_comb begin
        req_n = (state_n != PRESENT);
    end

endmodule
